// File: rtl/m_if_stage.sv
// m_if_stage: instruction fetch stage with a PC register and a 2-entry
// {pc, ir} skid FIFO feeding decode. Redirects flush the FIFO and reload PC.
// Optional feature macro IF_FETCH_CNT_EN: when defined, w_fcnt counts
// instructions handed to decode; otherwise w_fcnt is tied to zero.
module m_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        w_clk,
   input  logic        w_rst,
   output logic [31:0] w_pc,
   input  logic [31:0] w_insn,
   input  logic        w_redir,
   input  logic [31:0] w_redir_pc,
   output logic        w_id_valid,
   input  logic        w_id_ready,
   output logic [31:0] w_id_ir,
   output logic [31:0] w_id_pc,
   output logic [31:0] w_fcnt
);

   localparam int unsigned XLEN    = 32;
   localparam logic [XLEN-1:0] NOP = 32'h00000013;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   logic [XLEN-1:0] r_pc;
   logic [1:0]      r_cnt;
   logic [XLEN-1:0] r_pc0;
   logic [XLEN-1:0] r_ir0;
   logic [XLEN-1:0] r_pc1;
   logic [XLEN-1:0] r_ir1;

   logic w_xfer;
   logic w_fetch;

   // Handshake and fetch-enable decode; a transfer always frees a slot
   assign w_xfer  = (r_cnt != 2'd0) && w_id_ready;
   assign w_fetch = !w_redir && ((r_cnt != 2'd2) || w_xfer);

   // Outputs come straight from state; head slot is entry 0
   assign w_pc       = r_pc;
   assign w_id_valid = (r_cnt != 2'd0);
   assign w_id_pc    = (r_cnt != 2'd0) ? r_pc0 : '0;
   assign w_id_ir    = (r_cnt != 2'd0) ? r_ir0 : NOP;

   // PC and FIFO update: redirect wins, otherwise push/pop with shift-to-head
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         r_pc  <= RESET_PC;
         r_cnt <= 2'd0;
         r_pc0 <= '0;
         r_ir0 <= NOP;
         r_pc1 <= '0;
         r_ir1 <= NOP;
      end else if (w_redir) begin
         r_cnt <= 2'd0;
         r_pc  <= {w_redir_pc[XLEN-1:2], 2'b00};
      end else if (w_fetch) begin
         r_pc <= r_pc + PC_STEP;
         if (w_xfer) begin
            // Push and pop together: occupancy unchanged
            if (r_cnt == 2'd2) begin
               r_pc0 <= r_pc1;
               r_ir0 <= r_ir1;
               r_pc1 <= r_pc;
               r_ir1 <= w_insn;
            end else begin
               r_pc0 <= r_pc;
               r_ir0 <= w_insn;
            end
         end else begin
            if (r_cnt == 2'd0) begin
               r_pc0 <= r_pc;
               r_ir0 <= w_insn;
            end else begin
               r_pc1 <= r_pc;
               r_ir1 <= w_insn;
            end
            r_cnt <= r_cnt + 2'd1;
         end
      end
   end

`ifdef IF_FETCH_CNT_EN
   logic [XLEN-1:0] r_fcnt;

   // Delivered-instruction counter, includes transfers during a redirect
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         r_fcnt <= '0;
      end else if (w_xfer) begin
         r_fcnt <= r_fcnt + XLEN'(1);
      end
   end

   assign w_fcnt = r_fcnt;
`else
   assign w_fcnt = '0;
`endif

endmodule
